// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM states and capture-context payload for the multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned WORD    = 64;
    localparam int unsigned MD_OP_W = 3;
    localparam int unsigned RD_W    = 5;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MUL   = 3'd0,
        MD_SMULH = 3'd1,
        MD_UMULH = 3'd2,
        MD_SDIV  = 3'd3,
        MD_UDIV  = 3'd4
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Everything about the in-flight instruction that is not datapath.
    typedef struct packed {
        logic [MD_OP_W-1:0] op;
        logic [RD_W-1:0]    rd;
        logic               neg;
    } md_ctx_t;

    function automatic logic is_signed_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_SMULH) || (op == MD_SDIV);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_SDIV) || (op == MD_UDIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_twos_negate.sv
// Conditional two's-complement negate; used for operand magnitude and result sign fix.
module twos_negate #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// fixed WIDTH+1 cycle latency from capture to done for every op.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [RD_W-1:0]    rd_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [RD_W-1:0]    rd_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    md_state_e         state_q, state_d;
    md_ctx_t           ctx_q, ctx_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [RD_W-1:0]   rd_out_q, rd_out_d;

    logic              signed_c;
    logic              div_c;
    logic [WIDTH-1:0]  abs_a_c;
    logic [WIDTH-1:0]  abs_b_c;
    logic [ACC_W-1:0]  fix_c;

    assign signed_c = is_signed_op(op);
    assign div_c    = is_div_op(op);

    twos_negate #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (operand_a),
        .neg_i (signed_c & operand_a[WIDTH-1]),
        .res_o (abs_a_c)
    );

    twos_negate #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (operand_b),
        .neg_i (signed_c & operand_b[WIDTH-1]),
        .res_o (abs_b_c)
    );

    // Negating the whole accumulator fixes both the SMULH high half and the SDIV quotient
    // in the low half, since low bits of a negation depend only on low bits.
    twos_negate #(.WIDTH(ACC_W)) u_fix (
        .val_i (acc_q),
        .neg_i (ctx_q.neg),
        .res_o (fix_c)
    );

    // One shift-add step: accumulator holds {partial product high, remaining multiplier}.
    logic [WIDTH:0]    mul_sum_c;
    logic [ACC_W-1:0]  mul_next_c;

    assign mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    assign mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

    // One restoring step: accumulator holds {partial remainder, dividend/quotient bits}.
    logic [WIDTH:0]    rem_sh_c;
    logic [WIDTH-1:0]  rem_sub_c;
    logic              q_bit_c;
    logic [ACC_W-1:0]  div_next_c;

    assign rem_sh_c   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    assign q_bit_c    = (rem_sh_c >= {1'b0, opnd_q});
    assign rem_sub_c  = rem_sh_c[WIDTH-1:0] - opnd_q;
    assign div_next_c = {(q_bit_c ? rem_sub_c : rem_sh_c[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], q_bit_c};

    // Final result selection once all iterations are complete.
    logic              div_zero_c;
    logic [WIDTH-1:0]  fix_result_c;

    assign div_zero_c = (opnd_q == '0);

    always_comb begin
        fix_result_c = '0;
        case (ctx_q.op)
            MD_MUL:   fix_result_c = acc_q[WIDTH-1:0];
            MD_UMULH: fix_result_c = acc_q[ACC_W-1:WIDTH];
            MD_SMULH: fix_result_c = fix_c[ACC_W-1:WIDTH];
            MD_UDIV:  fix_result_c = div_zero_c ? '0 : acc_q[WIDTH-1:0];
            MD_SDIV:  fix_result_c = div_zero_c ? '0 : fix_c[WIDTH-1:0];
            default:  fix_result_c = '0;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        rd_out_d = rd_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctx_d.op  = op;
                    ctx_d.rd  = rd_in;
                    ctx_d.neg = signed_c & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    opnd_d    = div_c ? abs_b_c : abs_a_c;
                    acc_d     = {WIDTH'(0), (div_c ? abs_a_c : abs_b_c)};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = is_div_op(ctx_q.op) ? div_next_c : mul_next_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_result_c;
                rd_out_d = ctx_q.rd;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctx_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            ctx_q    <= ctx_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int unsigned W       = 64;
    localparam int unsigned LATENCY = W + 1;
    localparam logic [W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic [4:0]   rd_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   rd_out;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    mul_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one instruction, straight from the arithmetic definition.
    function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0]        up;
        logic signed [2*W-1:0] sp;
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: return up[W-1:0];
            3'd1: return sp[2*W-1:W];
            3'd2: return up[2*W-1:W];
            3'd3: begin
                if (b == '0) return '0;
                if (a == MIN_NEG && b == {W{1'b1}}) return MIN_NEG;
                return W'(sa / sb);
            end
            3'd4: return (b == '0) ? '0 : a / b;
            default: return '0;
        endcase
    endfunction

    // Transaction-level model: an accepted request yields its result LATENCY edges later.
    int           m_rem    = 0;
    logic         m_busy   = 1'b0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [4:0]   m_rd     = '0;
    logic [W-1:0] m_pend   = '0;
    logic [4:0]   m_pend_rd = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_rd = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1; m_busy = 1'b0; m_result = m_pend; m_rd = m_pend_rd;
                end
            end else if (start) begin
                m_pend    = ref_result(op, operand_a, operand_b);
                m_pend_rd = rd_in;
                m_rem     = LATENCY;
                m_busy    = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",   W'(busy),   W'(m_busy));
            check("cyc_done",   W'(done),   W'(m_done));
            check("cyc_result", result,     m_result);
            check("cyc_rd_out", W'(rd_out), W'(m_rd));
        end
    end

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = W'($urandom_range(0, 20));
            1: v = -W'($urandom_range(1, 20));
            2: v = '0;
            3: v = MIN_NEG;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Issue one op (captured at the next edge), then wait for done with a bounded budget.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] rd,
                          input logic [W-1:0] exp, input bit noise);
        int k;
        bit seen;
        op = o; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
        rd_in = 5'($urandom);
        k = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            if (noise && k == 10) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 4));
            end
            if (noise && k == 11) start = 1'b0;
            @(posedge clk);
            k++;
            #1;
            seen = done;
        end
        check({name, "_latency"}, W'(k), W'(LATENCY));
        check({name, "_result"}, result, exp);
        check({name, "_rd"}, W'(rd_out), W'(rd));
    endtask

    initial begin
        int  gap;
        bit  seen;
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [4:0]   rr;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   W'(busy),   '0);
        check("rst_done",   W'(done),   '0);
        check("rst_result", result,     '0);
        check("rst_rd_out", W'(rd_out), '0);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mul_7x6",   3'd0, 64'd7, 64'd6, 5'd3, 64'd42, 1'b0);
        @(negedge clk);
        run_op("smulh_m1x2", 3'd1, {W{1'b1}}, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("umulh_m1x2", 3'd2, {W{1'b1}}, 64'd2, 5'd5, 64'd1, 1'b0);
        @(negedge clk);
        run_op("sdiv_m7d2",  3'd3, -64'd7, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("udiv_100d7", 3'd4, 64'd100, 64'd7, 5'd7, 64'd14, 1'b0);
        run_op("udiv_5d0",   3'd4, 64'd5, 64'd0, 5'd8, 64'd0, 1'b0);
        run_op("sdiv_min_m1", 3'd3, MIN_NEG, {W{1'b1}}, 5'd9, MIN_NEG, 1'b0);
        run_op("reserved",   3'd6, 64'd9, 64'd9, 5'd10, 64'd0, 1'b0);

        @(negedge clk);
        run_op("mul_ignore_start", 3'd0, 64'd7, 64'd6, 5'd11, 64'd42, 1'b1);
        run_op("b2b_udiv", 3'd4, 64'd100, 64'd7, 5'd12, 64'd14, 1'b0);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        op = 3'd0; operand_a = 64'd1000; operand_b = 64'd1000; rd_in = 5'd13; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy",   W'(busy),   '0);
        check("abort_done",   W'(done),   '0);
        check("abort_result", result,     '0);
        check("abort_rd_out", W'(rd_out), '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", W'(seen), '0);
        @(negedge clk);
        run_op("mul_3x5", 3'd0, 64'd3, 64'd5, 5'd14, 64'd15, 1'b0);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            ro = 3'($urandom_range(0, 7));
            ra = rnd_word();
            rb = rnd_word();
            rr = 5'($urandom);
            run_op("rand", ro, ra, rb, rr, ref_result(ro, ra, rb), (i % 3) == 0);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
